// File: rtl/sm_trace_buffer.sv
// Instruction-trace capture for schoolMIPS: records {pc, instr, stamp} into a
// circular buffer while armed, stops on freeze or cycle timeout, indexed readback.
module sm_trace_buffer #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 16,
    parameter int STOP_CYCLES = 120,
    parameter int STAMP_WIDTH = 16,
    parameter int SKIP_NOP    = 0,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic [PC_WIDTH-1:0]    pc_in,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    input  logic                   arm,
    input  logic                   freeze,
    input  logic [AW-1:0]          rd_idx,
    output logic                   rd_valid,
    output logic [PC_WIDTH-1:0]    rd_pc,
    output logic [INSTR_WIDTH-1:0] rd_instr,
    output logic [STAMP_WIDTH-1:0] rd_stamp,
    output logic [AW:0]            count,
    output logic                   running,
    output logic                   done,
    output logic                   timeout
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] STOPPED = 2'd2;

    localparam int ENTRY_W = PC_WIDTH + INSTR_WIDTH + STAMP_WIDTH;
    localparam logic [STAMP_WIDTH-1:0] STOP_LAST =
        STAMP_WIDTH'((STOP_CYCLES == 0) ? 0 : STOP_CYCLES - 1);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [1:0]             state;
    logic [1:0]             stateNext;
    logic [AW-1:0]          wrPtr;
    logic [AW:0]            countReg;
    logic [STAMP_WIDTH-1:0] stampCnt;
    logic                   runningReg;
    logic                   doneReg;
    logic                   timeoutReg;
    logic                   rdValidReg;
    logic [ENTRY_W-1:0]     rdWord;
    logic [AW-1:0]          rdAddr;
    logic                   capture;
    logic                   timeoutHit;

    logic [ENTRY_W-1:0] mem [DEPTH];

    assign capture    = (state == RUN) && !arm && valid_in &&
                        !((SKIP_NOP != 0) && (instr_in == '0));
    assign timeoutHit = (STOP_CYCLES != 0) && (state == RUN) && (stampCnt == STOP_LAST);

    // Once full, the oldest entry sits at wrPtr; before that it sits at 0.
    assign rdAddr = ((countReg == FULL) ? wrPtr : '0) + rd_idx;

    always_comb begin
        stateNext = state;
        if (arm)
            stateNext = RUN;
        else if (state == RUN && (freeze || timeoutHit))
            stateNext = STOPPED;
    end

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (capture)
            mem[wrPtr] <= {pc_in, instr_in, stampCnt};
        rdWord <= mem[rdAddr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wrPtr      <= '0;
            countReg   <= '0;
            stampCnt   <= '0;
            runningReg <= 1'b0;
            doneReg    <= 1'b0;
            timeoutReg <= 1'b0;
            rdValidReg <= 1'b0;
        end else begin
            state      <= stateNext;
            runningReg <= (stateNext == RUN);
            doneReg    <= (stateNext == STOPPED);
            rdValidReg <= ({1'b0, rd_idx} < countReg);
            timeoutReg <= 1'b0;
            if (arm) begin
                wrPtr    <= '0;
                countReg <= '0;
                stampCnt <= '0;
            end else if (state == RUN) begin
                if (capture) begin
                    wrPtr <= wrPtr + 1'b1;
                    if (countReg != FULL)
                        countReg <= countReg + 1'b1;
                end
                if (stampCnt != '1)
                    stampCnt <= stampCnt + 1'b1;
                timeoutReg <= timeoutHit;
            end
        end
    end

    // Validity is reset asynchronously, so gating the RAM word with it zeroes
    // the data outputs immediately on reset and for out-of-range indices.
    assign rd_valid = rdValidReg;
    assign rd_pc    = rdValidReg ? rdWord[ENTRY_W-1 -: PC_WIDTH]               : '0;
    assign rd_instr = rdValidReg ? rdWord[STAMP_WIDTH +: INSTR_WIDTH]          : '0;
    assign rd_stamp = rdValidReg ? rdWord[STAMP_WIDTH-1:0]                     : '0;
    assign count    = countReg;
    assign running  = runningReg;
    assign done     = doneReg;
    assign timeout  = timeoutReg;
endmodule

// File: tb/tb_sm_trace_buffer.sv
// Randomized and directed bench for sm_trace_buffer with a queue-based trace model
// and a scoreboard monitor that checks every clock edge's outputs.
module tb_sm_trace_buffer;
    localparam int DEPTH = 16;
    localparam int STOP  = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] pc_in = '0;
    logic [31:0] instr_in = '0;
    logic        arm = 1'b0;
    logic        freeze = 1'b0;
    logic [3:0]  rd_idx = '0;
    logic        rd_valid;
    logic [31:0] rd_pc;
    logic [31:0] rd_instr;
    logic [15:0] rd_stamp;
    logic [4:0]  count;
    logic        running;
    logic        done;
    logic        timeout;

    sm_trace_buffer #(
        .PC_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(DEPTH),
        .STOP_CYCLES(STOP), .STAMP_WIDTH(16), .SKIP_NOP(1)
    ) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .pc_in(pc_in),
        .instr_in(instr_in), .arm(arm), .freeze(freeze), .rd_idx(rd_idx),
        .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr),
        .rd_stamp(rd_stamp), .count(count), .running(running),
        .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [15:0] st;
        logic [4:0]  cnt;
        logic        run;
        logic        dn;
        logic        to;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        int          st;
    } ent_t;

    exp_t expQ[$];
    ent_t trace[$];     // oldest entry first
    int   mStamp = 0;
    int   mState = 0;   // 0 idle, 1 run, 2 stopped
    bit   mTo    = 1'b0;
    int   total  = 0;
    int   bad    = 0;
    int   txn    = 0;
    exp_t got;
    exp_t want;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end else
            $display("check %s ok (%0h)", name, act);
    endfunction

    // One clock of stimulus; the model computes what the following edge must produce.
    task automatic cycle(input bit a, input bit f, input bit v,
                         input logic [31:0] p, input logic [31:0] i, input int idx);
        exp_t e;
        bit   hit;
        @(negedge clk);
        arm = a; freeze = f; valid_in = v; pc_in = p; instr_in = i;
        rd_idx = 4'(idx);
        e = '0;
        if (idx < trace.size()) begin
            e.v   = 1'b1;
            e.pc  = trace[idx].pc;
            e.ins = trace[idx].ins;
            e.st  = 16'(trace[idx].st);
        end
        if (a) begin
            trace.delete();
            mStamp = 0;
            mState = 1;
            mTo    = 1'b0;
        end else if (mState == 1) begin
            hit = (mStamp == STOP - 1);
            if (v && i != 0) begin
                if (trace.size() == DEPTH) void'(trace.pop_front());
                trace.push_back('{pc: p, ins: i, st: mStamp});
            end
            if (mStamp < 65535) mStamp++;
            if (f || hit) mState = 2;
            mTo = hit;
        end else
            mTo = 1'b0;
        e.cnt = 5'(trace.size());
        e.run = (mState == 1);
        e.dn  = (mState == 2);
        e.to  = mTo;
        expQ.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: pops one expectation per edge and compares against the DUT.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                want = expQ.pop_front();
                got  = {rd_valid, rd_pc, rd_instr, rd_stamp, count, running, done, timeout};
                total++;
                txn++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL edge%0d: got v=%0b pc=%h in=%h st=%0d cnt=%0d run=%0b dn=%0b to=%0b required v=%0b pc=%h in=%h st=%0d cnt=%0d run=%0b dn=%0b to=%0b",
                             txn, got.v, got.pc, got.ins, got.st, got.cnt, got.run, got.dn, got.to,
                             want.v, want.pc, want.ins, want.st, want.cnt, want.run, want.dn, want.to);
                end else
                    $display("edge%0d ok v=%0b pc=%h st=%0d cnt=%0d run=%0b dn=%0b to=%0b",
                             txn, got.v, got.pc, got.st, got.cnt, got.run, got.dn, got.to);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("reset_count", 64'(count), 0);
        chk("reset_running", 64'(running), 0);
        chk("reset_done", 64'(done), 0);
        chk("reset_rd_valid", 64'(rd_valid), 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic capture
        cycle(1, 0, 0, 0, 0, 0);
        for (int p = 0; p < 5; p++) cycle(0, 0, 1, 32'(p), 32'h24020001 + 32'(p), 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        settle();
        chk("basic_count", 64'(count), 5);
        chk("basic_done", 64'(done), 1);
        chk("basic_idx0_pc", 64'(rd_pc), 0);
        chk("basic_idx0_stamp", 64'(rd_stamp), 0);
        cycle(0, 0, 0, 0, 0, 4);
        settle();
        chk("basic_idx4_pc", 64'(rd_pc), 4);
        chk("basic_idx4_stamp", 64'(rd_stamp), 4);
        cycle(0, 0, 0, 0, 0, 5);
        settle();
        chk("basic_idx5_valid", 64'(rd_valid), 0);
        chk("basic_idx5_pc", 64'(rd_pc), 0);

        // Wrap-around
        cycle(1, 0, 0, 0, 0, 0);
        for (int p = 0; p < 20; p++) cycle(0, 0, 1, 32'(p), 32'h24020001 + 32'(p), 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        settle();
        chk("wrap_count", 64'(count), 16);
        chk("wrap_idx0_pc", 64'(rd_pc), 4);
        chk("wrap_idx0_stamp", 64'(rd_stamp), 4);
        cycle(0, 0, 0, 0, 0, 15);
        settle();
        chk("wrap_idx15_pc", 64'(rd_pc), 19);
        chk("wrap_idx15_stamp", 64'(rd_stamp), 19);

        // Timeout with valid held high
        cycle(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 30; k++) cycle(0, 0, 1, 32'(100 + k), 32'h1000 + 32'(k), k % 16);
        cycle(0, 0, 0, 0, 0, 0);
        settle();
        chk("timeout_count", 64'(count), 16);
        chk("timeout_done", 64'(done), 1);
        chk("timeout_idx0_stamp", 64'(rd_stamp), 8);

        // Nop filtering
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 32'h40, 32'h24020001, 0);
        cycle(0, 0, 1, 32'h44, 32'h0, 0);
        cycle(0, 0, 1, 32'h48, 32'h0, 0);
        cycle(0, 0, 1, 32'h4c, 32'h00441021, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        settle();
        chk("nop_count", 64'(count), 2);
        chk("nop_idx1_stamp", 64'(rd_stamp), 3);

        // Simultaneous arm and freeze in RUN
        cycle(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 1, 32'(k), 32'h77, 0);
        cycle(1, 1, 1, 32'h9, 32'h77, 0);
        settle();
        chk("armfrz_running", 64'(running), 1);
        chk("armfrz_count", 64'(count), 0);
        cycle(0, 0, 1, 32'h50, 32'h88, 0);
        cycle(0, 0, 0, 0, 0, 0);
        settle();
        chk("armfrz_stamp_restart", 64'(rd_stamp), 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        settle();
        chk("arm_stopped_running", 64'(running), 1);

        // Arm on the timeout edge suppresses the pulse
        for (int k = 0; k < STOP - 1; k++) cycle(0, 0, 1, 32'(k), 32'h55, 0);
        cycle(1, 0, 1, 32'h99, 32'h55, 0);
        settle();
        chk("arm_timeout_pulse", 64'(timeout), 0);
        chk("arm_timeout_running", 64'(running), 1);

        // Asynchronous reset between edges
        for (int k = 0; k < 4; k++) cycle(0, 0, 1, 32'(k), 32'h66, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_count", 64'(count), 0);
        chk("async_running", 64'(running), 0);
        chk("async_rd_valid", 64'(rd_valid), 0);
        chk("async_rd_pc", 64'(rd_pc), 0);
        trace.delete();
        mStamp = 0;
        mState = 0;
        mTo    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) cycle(0, 0, 1, 32'(k), 32'h66, 0);
        settle();
        chk("post_reset_count", 64'(count), 0);
        chk("post_reset_running", 64'(running), 0);

        // Randomized traffic
        for (int n = 0; n < 350; n++) begin
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 3) != 0, $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                  int'($urandom_range(0, 15)));
        end
        cycle(0, 0, 0, 0, 0, 0);

        for (int w = 0; w < 10 && expQ.size() > 0; w++) @(posedge clk);
        #2;
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sm_trace_buffer.md
# sm_trace_buffer

Synthesizable instruction-trace capture unit for the schoolMIPS core. It records per-cycle `{pc, instr, cycle stamp}` entries into a circular buffer of parametrised depth and optionally filters out nops. Capture stops on a programmable cycle timeout or an explicit freeze. The buffer is read back through an indexed, registered read port. It sits beside `sm_cpu` inside `sm_top`, fed from the CPU PC and instruction buses. It replaces simulation-only trace printing with an on-chip equivalent usable on FPGA.

## Interface
- `PC_WIDTH`, default 32: width of the captured PC.
- `INSTR_WIDTH`, default 32: width of the captured instruction.
- `DEPTH`, default 16: number of entries; must be a power of two, ≥2. `AW = $clog2(DEPTH)`.
- `STOP_CYCLES`, default 120: run-window length in clocks; 0 disables the timeout.
- `STAMP_WIDTH`, default 16: cycle-stamp width; the counter saturates at all-ones.
- `SKIP_NOP`, default 0: when 1, entries with `instr_in == 0` are not recorded.

Ports:
- `clk  in  1`  system clock, posedge.
- `rst  in  1`  asynchronous, active-high reset.
- `valid_in  in  1`  an instruction is presented this cycle.
- `pc_in  in  PC_WIDTH`  PC of the presented instruction.
- `instr_in  in  INSTR_WIDTH`  instruction word.
- `arm  in  1`  single-cycle pulse that clears the buffer and starts capture.
- `freeze  in  1`  single-cycle pulse that stops capture.
- `rd_idx  in  AW`  logical read index; 0 = oldest entry.
- `rd_valid  out  1`  `rd_idx` addressed a held entry (registered).
- `rd_pc  out  PC_WIDTH`, `rd_instr  out  INSTR_WIDTH`, `rd_stamp  out  STAMP_WIDTH`  read data (registered).
- `count  out  AW+1`  number of held entries, 0..DEPTH.
- `running  out  1`  high while in RUN.
- `done  out  1`  high while in STOPPED.
- `timeout  out  1`  one-cycle pulse when the timeout ends RUN.

## Operation
- FSM states: IDLE → RUN → STOPPED.
  - IDLE: entered on reset; transitions to RUN on `arm`.
  - RUN: `freeze` or timeout → STOPPED; `arm` → restart in RUN.
  - STOPPED: `arm` → RUN.
  - `arm` wins over a simultaneous `freeze` or timeout.
- On `arm`: `wr_ptr`, `count` and `stamp_cnt` are cleared to 0 and the state becomes RUN. No capture occurs on the arming edge.
- In RUN, every clock edge:
  - If `valid_in && !(SKIP_NOP && instr_in == 0)`, write `{pc_in, instr_in, stamp_cnt}` at `wr_ptr`.
  - `wr_ptr` increments modulo DEPTH.
  - `count` saturates at DEPTH; once full, the oldest entry is overwritten.
  - `stamp_cnt` increments every RUN edge whether or not an entry was written, and saturates.
- Timeout: at a RUN edge where `STOP_CYCLES != 0` and `stamp_cnt == STOP_CYCLES-1`:
  - Capture still occurs on that edge.
  - Next state is STOPPED and `timeout` = 1 for the following cycle.
  - Result: exactly `STOP_CYCLES` edges are observed.
- `freeze` edge: capture on that same edge still occurs, then the state becomes STOPPED. `timeout` stays 0.
- IDLE and STOPPED: no writes; the buffer and `count` are held for readout.
- Read:
  - Physical address = `(count == DEPTH ? wr_ptr : 0) + rd_idx`, modulo DEPTH.
  - `rd_valid = (rd_idx < count)`.
  - When `rd_valid` = 0, the data outputs are driven to 0.
  - Reads are legal in every state. During RUN they return a moving window.
- Memory is a plain array with no reset. Entries beyond `count` are never exposed.

## Timing
- Reset values, forced asynchronously:
  - State IDLE.
  - `count`, `wr_ptr`, `stamp_cnt` = 0.
  - `rd_valid`, `rd_pc`, `rd_instr`, `rd_stamp` = 0.
  - `running`, `done`, `timeout` = 0.
- Reset mid-RUN: outputs drop immediately without a clock; buffer contents are discarded logically (`count` = 0).
- `running` and `done` are registered state decodes; they change on the edge that changes state.
- Write-to-read: an entry written at edge N is readable by `rd_idx` sampled at edge N+1, with data valid after edge N+1.
- Read latency: 1 clock (`rd_idx` sampled at edge N → outputs updated at edge N, stable through N+1).
- `count` updates on the same edge as the write.

## Test plan
- **Basic capture:** reset, `arm`, then 5 consecutive valid cycles with pc 0..4 and instr 0x24020001+pc, then `freeze` → `count`=5, `done`=1. `rd_idx` 0 gives pc 0, stamp 0. `rd_idx` 4 gives pc 4, stamp 4. `rd_idx` 5 gives `rd_valid`=0 and zero data.
- **Wrap-around (DEPTH=16):** 20 consecutive valid cycles → `count`=16. `rd_idx` 0 gives pc 4, stamp 4. `rd_idx` 15 gives pc 19, stamp 19.
- **Timeout (STOP_CYCLES=8), `valid_in` held 1:** exactly 8 entries, stamps 0..7. `timeout` pulses once, in the cycle after the 8th RUN edge. `running` falls and `done` rises on that edge. Further valid input is ignored.
- **SKIP_NOP=1:** instr sequence 0x24020001, 0, 0, 0x00441021, all valid → `count`=2 with stamps 0 and 3. Stamp gaps prove nop cycles are counted but not stored.
- **Simultaneous events:**
  - `arm` and `freeze` in the same cycle during RUN → state stays RUN, `count`=0, `stamp_cnt`=0.
  - `arm` in STOPPED restarts capture.
  - `arm` in the timeout cycle suppresses the `timeout` pulse.
- **Async reset:** assert `rst` mid-RUN between clock edges → `count`, `running` and all read outputs go to 0 before the next edge. After release, state is IDLE and valid input is ignored until `arm`.
